// File: rtl/int_req_ctrl_if.sv
// int_req_ctrl_if: bundles the interrupt lines, the core handshake and the
// controller's request outputs into one port.
//   master : interrupt pins + core side (drives irq_src, irq_mask, int_taken,
//            eret; observes ext_int, int_finished, int_id, int_pending)
//   slave  : the controller (int_req_ctrl)
interface int_req_ctrl_if #(
  parameter int NUM_SRC = 6,
  parameter int ID_W    = 3
);
  logic [NUM_SRC-1:0] irq_src;
  logic [NUM_SRC-1:0] irq_mask;
  logic               int_taken;
  logic               eret;
  logic               ext_int;
  logic               int_finished;
  logic [ID_W-1:0]    int_id;
  logic [NUM_SRC-1:0] int_pending;

  modport master (
    output irq_src, irq_mask, int_taken, eret,
    input  ext_int, int_finished, int_id, int_pending
  );

  modport slave (
    input  irq_src, irq_mask, int_taken, eret,
    output ext_int, int_finished, int_id, int_pending
  );
endinterface

// File: rtl/int_req_ctrl.sv
// int_req_ctrl: synchronises up to NUM_SRC asynchronous interrupt lines,
// keeps a pending register, masks and picks the lowest-index candidate, and
// runs the request through acceptance (int_taken) and handler exit (eret),
// finishing with a one-cycle int_finished pulse.
//
// Ports:
//   clk    core clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    int_req_ctrl_if.slave: irq_src, irq_mask, int_taken, eret in;
//          ext_int, int_finished, int_id, int_pending out
//
// Build option: define INT_EDGE_TRIG_EN for edge-triggered, sticky pending
// bits cleared by int_taken. Without it the pending register is simply the
// registered synchroniser output (level-triggered).
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no request; latch the winning candidate when one exists
// ASSERT  | ext_int high, waiting for int_taken (or mask/line withdrawal)
// SERVICE | handler running, no nesting, waiting for eret
// DONE    | int_finished pulse for one cycle
module int_req_ctrl #(
  parameter int NUM_SRC = 6,
  parameter int ID_W    = 3
) (
  input logic           clk,
  input logic           rst_n,
  int_req_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE, DONE} state_t;

  state_t             state, state_nxt;
  logic [NUM_SRC-1:0] sync_q1, sync_q2;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] cand;
  logic [NUM_SRC-1:0] sel_oh;
  logic [ID_W-1:0]    int_id;
  logic [ID_W-1:0]    win_id;
  logic               win_vld;
  logic               cur_vld;
  logic               take;
  logic               load_id;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= bus.irq_src;
      sync_q2 <= sync_q1;
    end
  end

  assign take = (state == ASSERT) && bus.int_taken;

`ifdef INT_EDGE_TRIG_EN
  logic [NUM_SRC-1:0] prev;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr;
  logic [1:0]         settle_cnt;

  // The synchroniser restarts from zero after reset, so a line that was
  // already high would look like a fresh edge. Edge detection is held off
  // until the chain and prev register carry real samples.
  assign rise = (settle_cnt == 2'd0) ? (sync_q2 & ~prev) : '0;
  assign clr  = take ? sel_oh : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev       <= '0;
      settle_cnt <= 2'd3;
      pending    <= '0;
    end else begin
      prev <= sync_q2;
      if (settle_cnt != 2'd0)
        settle_cnt <= settle_cnt - 2'd1;
      // set has priority over the int_taken clear
      pending <= (pending & ~clr) | rise;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n)
      pending <= '0;
    else
      pending <= sync_q2;
  end
`endif

  assign cand = pending & bus.irq_mask;

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NUM_SRC; i++)
      sel_oh[i] = (int_id == ID_W'(i));
  end

  assign cur_vld = |(cand & sel_oh);

  // descending scan so the lowest set index is the one left standing
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      int_id <= '0;
    end else begin
      state <= state_nxt;
      if (load_id)
        int_id <= win_id;
    end
  end

  always_comb begin
    state_nxt = state;
    load_id   = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          load_id   = 1'b1;
          state_nxt = ASSERT;
        end
      end
      ASSERT: begin
        if (take)
          state_nxt = SERVICE;
        else if (!cur_vld)
          state_nxt = IDLE;
      end
      SERVICE: begin
        if (bus.eret)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ext_int      = (state == ASSERT);
  assign bus.int_finished = (state == DONE);
  assign bus.int_id       = int_id;
  assign bus.int_pending  = pending;

endmodule
